// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing constants, frame length helper and arbiter state type
package uart_pkg;

    localparam int CYCLES_PER_SAMPLE = 697394;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} ArbState;

    function automatic int frame_cycles(input int cps, input int guard);
        return 10 * cps + guard;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake and transmitter-facing signals of the arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]   i_req_valid;
    logic [8*NUM_REQ-1:0] i_req_data;
    logic [NUM_REQ-1:0]   o_req_ready;
    logic [7:0]           o_tx_data;
    logic                 o_tx_start;
    logic                 o_busy;
    logic [2:0]           o_grant_id;
    logic [15:0]          o_frames_sent;

    modport slave (
        input  i_req_valid, i_req_data,
        output o_req_ready, o_tx_data, o_tx_start, o_busy, o_grant_id, o_frames_sent
    );

    modport master (
        output i_req_valid, i_req_data,
        input  o_req_ready, o_tx_data, o_tx_start, o_busy, o_grant_id, o_frames_sent
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from the entry after ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic          found;
    logic [IW-1:0] idx;

    // first requesting index after ptr, wrapping modulo N
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign grant = found ? (N'(1) << grant_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter, timing each frame locally
module uart_tx_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int CYCLES_PER_SAMPLE = uart_pkg::CYCLES_PER_SAMPLE,
    parameter int GUARD_CYCLES      = 2
) (
    input logic              clk,
    input logic              r_reset,
    uart_tx_arbiter_if.slave bus
);

    import uart_pkg::*;

    localparam int FRAME_CYCLES = frame_cycles(CYCLES_PER_SAMPLE, GUARD_CYCLES);
    localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);
    localparam int IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    ArbState            state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      win_idx;
    logic [NUM_REQ-1:0] win;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic [2:0]         grant_id;
    logic [15:0]        frames_sent;
    logic [7:0]         req_byte [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_byte[g] = bus.i_req_data[8*g +: 8];
    end

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req       (bus.i_req_valid),
        .ptr       (ptr),
        .grant     (win),
        .grant_idx (win_idx)
    );

    assign bus.o_req_ready   = (state == IDLE) ? win : '0;
    assign bus.o_tx_data     = tx_data;
    assign bus.o_tx_start    = tx_start;
    assign bus.o_busy        = state != IDLE;
    assign bus.o_grant_id    = grant_id;
    assign bus.o_frames_sent = frames_sent;

    // grant in IDLE, pulse start in ISSUE, then count out frame plus guard in WAIT
    always_ff @(posedge clk) begin
        if (r_reset) begin
            state       <= IDLE;
            ptr         <= IW'(NUM_REQ - 1);
            cnt         <= '0;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            grant_id    <= 3'd0;
            frames_sent <= 16'd0;
        end else begin
            case (state)
                IDLE: if (|bus.i_req_valid) begin
                    tx_data  <= req_byte[win_idx];
                    grant_id <= 3'(win_idx);
                    ptr      <= win_idx;
                    tx_start <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    tx_start <= 1'b0;
                    cnt      <= CNT_W'(FRAME_CYCLES - 1);
                    state    <= WAIT;
                end
                WAIT: if (cnt == '0) begin
                    frames_sent <= frames_sent + 16'd1;
                    state       <= IDLE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_transmitter among NUM_REQ byte producers using round-robin arbitration.
- Issues one start pulse per byte to the transmitter and holds the byte stable.
- The transmitter has no done/ready output, so this block times each frame with its own counter and accepts no new byte until the frame plus a guard interval has elapsed.
- Sits directly in front of uart_transmitter; its outputs drive i_data and i_start_transmission.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CYCLES_PER_SAMPLE, 697394, clock cycles per UART bit; must equal the transmitter's value.
- GUARD_CYCLES, 2, extra idle cycles after each frame; minimum 2, covering the transmitter's input register stage.

Ports:
- clk  input  1  system clock
- r_reset  input  1  reset, synchronous, active-high
- i_req_valid  input  NUM_REQ  per-requester byte-valid
- i_req_data  input  8*NUM_REQ  requester k's byte is bits [8k+7:8k]
- o_req_ready  output  NUM_REQ  one-hot accept pulse
- o_tx_data  output  8  byte to transmitter i_data
- o_tx_start  output  1  single-cycle start pulse to transmitter
- o_busy  output  1  high whenever state != IDLE
- o_grant_id  output  3  index of last granted requester
- o_frames_sent  output  16  completed-frame counter, wraps

Behaviour:
- Localparams:
  - FRAME_CYCLES = 10*CYCLES_PER_SAMPLE + GUARD_CYCLES.
  - CNT_W = $clog2(FRAME_CYCLES+1).
- Reset (clock edge with r_reset=1), all registered, values visible from the next cycle:
  - state=IDLE; o_req_ready=0; o_tx_start=0; o_tx_data=8'h00; o_busy=0; o_grant_id=0; o_frames_sent=0; wait counter=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-frame aborts the wait with no frame counted. The system also resets the transmitter.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - No valid requester: stay in IDLE.
  - Any i_req_valid set: winner is the first valid index searching upward from pointer+1, modulo NUM_REQ.
  - Same cycle: o_req_ready[winner]=1 (combinational, derived from state and i_req_valid). The handshake completes on valid&ready.
  - Next edge: capture the winner's byte into o_tx_data, set o_grant_id=winner and pointer=winner, go to ISSUE.
- ISSUE: lasts exactly one cycle.
  - o_tx_start=1.
  - Load wait counter with FRAME_CYCLES-1; go to WAIT.
- WAIT:
  - o_tx_start=0; decrement the counter each cycle.
  - When the counter is 0: go to IDLE and increment o_frames_sent (16-bit wrap, FFFF->0000).
- Output hold:
  - o_tx_data is held constant from ISSUE through the end of WAIT.
  - o_tx_data keeps its value in IDLE until the next capture.
- Latency, with valid seen in IDLE at cycle t:
  - ready at t; o_tx_start at t+1.
  - Next grant possible at t+2+FRAME_CYCLES (ISSUE at t+1, WAIT from t+2 for FRAME_CYCLES cycles, IDLE at t+2+FRAME_CYCLES).
- o_req_ready is 0 in ISSUE and WAIT. A requester's valid, once raised, must stay high with stable data until its ready pulse.
- Valid dropped before grant: no grant, no start.
- All requesters valid continuously: grants rotate 0,1,2,3,0,... and no requester waits more than NUM_REQ frames.
- o_tx_start is never asserted in two consecutive cycles and never outside ISSUE.

Decomposition:
- Package uart_pkg holds:
  - CYCLES_PER_SAMPLE default;
  - the frame_cycles function (10*cps + guard);
  - the typedef enum ArbState {IDLE, ISSUE, WAIT}.
  - uart_transmitter later imports CYCLES_PER_SAMPLE from the same package.
- Sub-module rr_arbiter, parameterized by N:
  - inputs: request vector, pointer;
  - outputs: one-hot grant and grant index;
  - purely combinational.
- The FSM, counter and data register stay in uart_tx_arbiter.

Test Plan (all scenarios use CYCLES_PER_SAMPLE=4, GUARD_CYCLES=2, so FRAME_CYCLES=42):
- Reset, then idle for 100 cycles -> o_tx_start never 1, o_busy=0, o_frames_sent=0, o_req_ready=0.
- Requester 2 only, valid with 8'hA5 at cycle t -> o_req_ready=4'b0100 at t; o_tx_start=1 with o_tx_data=8'hA5 at t+1; o_busy=0 at t+44; o_frames_sent=1. With the transmitter attached, o_tx sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
- All 4 requesters valid continuously with bytes 8'h10..8'h13 -> grant order 0,1,2,3,0; start pulses spaced exactly 44 cycles apart; o_grant_id follows the grant order.
- Requesters 1 and 3 valid with pointer=1 after a grant to 1 -> 3 is granted before 1.
- r_reset asserted 20 cycles into WAIT -> next cycle state=IDLE, o_busy=0, o_frames_sent unchanged at 0, o_tx_start=0. A pending request is granted to requester 0's priority order on the first cycle after reset release.
- Force o_frames_sent=16'hFFFF via 65535 frames (or a backdoor), complete one more frame -> 16'h0000.
